// File: rtl/kfmmc_pkg.sv
// Shared definitions for the MMC/SD data-line datapath: engine states,
// the CRC16-CCITT polynomial and the released (idle) data-line levels.
package kfmmc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] CRC16_POLY     = 16'h1021;
  localparam logic        DAT_IDLE_LEVEL = 1'b1;
  localparam logic        DAT_IDLE_OE    = 1'b0;

  // One MSB-first serial step of CRC16-CCITT.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/kfmmc_data_line_shifter_if.sv
// Per-byte command/response bundle between the byte-level data I/O
// sequencer (master) and the bit-level data-line shifter (slave).
interface kfmmc_data_line_shifter_if;
  logic       start_communication;
  logic       data_io;
  logic       check_data_start_bit;
  logic       read_continuous_data;
  logic       clear_data_crc;
  logic       clear_data_interrupt;
  logic       mask_data_interrupt;
  logic       set_send_data;
  logic [7:0] send_data;
  logic [7:0] received_data;
  logic       in_connecting;
  logic       sent_data_interrupt;
  logic       received_data_interrupt;
  logic       start_bit_timeout;
  logic [15:0] data_crc;

  modport master (
    output start_communication, data_io, check_data_start_bit, read_continuous_data,
           clear_data_crc, clear_data_interrupt, mask_data_interrupt, set_send_data,
           send_data,
    input  received_data, in_connecting, sent_data_interrupt, received_data_interrupt,
           start_bit_timeout, data_crc
  );

  modport slave (
    input  start_communication, data_io, check_data_start_bit, read_continuous_data,
           clear_data_crc, clear_data_interrupt, mask_data_interrupt, set_send_data,
           send_data,
    output received_data, in_connecting, sent_data_interrupt, received_data_interrupt,
           start_bit_timeout, data_crc
  );
endinterface

// File: rtl/kfmmc_crc16_serial.sv
// Bit-serial CRC16-CCITT accumulator, shared by the data and command lines.
module kfmmc_crc16_serial
  import kfmmc_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_enable,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  // Clear has priority so a new frame never folds in a stale bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_crc <= '0;
    else if (i_clear)  r_crc <= '0;
    else if (i_enable) r_crc <= crc16_next(r_crc, i_bit);
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/kfmmc_data_line_shifter.sv
// MMC/SD data-line engine: generates mmc_clk and moves one byte per
// sequencer command, MSB first, with optional start-bit hunt on receive.
module kfmmc_data_line_shifter
  import kfmmc_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                            clock,
  input  logic                            reset,
  kfmmc_data_line_shifter_if.slave        bus,
  output logic                            mmc_clk,
  output logic                            mmc_dat_out,
  output logic                            mmc_dat_oe,
  input  logic                            mmc_dat_in
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HUNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [HUNT_W-1:0] HUNT_LIMIT = HUNT_W'(START_TIMEOUT);

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic [HUNT_W-1:0]   r_hunt_cnt;
  logic [3:0]          r_bitcnt;
  logic [7:0]          r_shreg;
  logic [7:0]          r_rx_data;
  logic [1:0]          r_sync;
  logic                r_mmc_clk, r_dat_out, r_dat_oe, r_dir, r_busy;
  logic                r_sent_flag, r_recv_flag, r_to_flag;

  logic                w_tick, w_rise, w_fall, w_din, w_bit, w_load;
  logic                w_crc_clear, w_crc_en;
  logic [15:0]         w_crc;
  state_t              w_first_state;

  assign w_din  = r_sync[1];
  assign w_bit  = r_dir ? w_din : r_shreg[7];
  assign w_load = bus.set_send_data & ~bus.data_io;
  assign w_tick = (r_state == ST_HUNT || r_state == ST_SHIFT) && (r_div == DIV_LAST);
  assign w_rise = w_tick & ~r_mmc_clk;
  assign w_fall = w_tick &  r_mmc_clk;

  assign w_crc_clear = (r_state == ST_IDLE) & bus.start_communication & bus.clear_data_crc;
  assign w_crc_en    = (r_state == ST_SHIFT) & w_rise;

  // First active state: hunt only on a receive that asks for it; a receive
  // with neither mode bit set behaves as a continuous read.
  always_comb begin
    w_first_state = ST_SHIFT;
    if (bus.data_io) begin
      if (bus.check_data_start_bit)      w_first_state = ST_HUNT;
      else if (bus.read_continuous_data) w_first_state = ST_SHIFT;
      else                               w_first_state = ST_SHIFT;
    end
  end

  // Two-flop synchroniser on the card data line; idles high like the bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], mmc_dat_in};
  end

  // Transfer engine: divider, mmc_clk, shift register and flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_div       <= '0;
      r_hunt_cnt  <= '0;
      r_bitcnt    <= '0;
      r_shreg     <= '0;
      r_rx_data   <= 8'h00;
      r_mmc_clk   <= 1'b0;
      r_dat_out   <= DAT_IDLE_LEVEL;
      r_dat_oe    <= DAT_IDLE_OE;
      r_dir       <= 1'b0;
      r_busy      <= 1'b0;
      r_sent_flag <= 1'b0;
      r_recv_flag <= 1'b0;
      r_to_flag   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_mmc_clk <= 1'b0;
          r_div     <= '0;
          if (bus.start_communication) begin
            r_busy     <= 1'b1;
            r_bitcnt   <= '0;
            r_hunt_cnt <= '0;
            r_dir      <= bus.data_io;
            r_state    <= w_first_state;
            if (bus.clear_data_interrupt) begin
              r_sent_flag <= 1'b0;
              r_recv_flag <= 1'b0;
              r_to_flag   <= 1'b0;
            end
            if (w_load) r_shreg <= bus.send_data;
            r_dat_oe  <= ~bus.data_io;
            r_dat_out <= bus.data_io ? DAT_IDLE_LEVEL
                                     : (w_load ? bus.send_data[7] : r_shreg[7]);
          end
        end
        ST_HUNT: begin
          r_div <= w_tick ? '0 : r_div + DIV_W'(1);
          if (w_rise) begin
            r_mmc_clk  <= 1'b1;
            r_hunt_cnt <= r_hunt_cnt + HUNT_W'(1);
            if (!w_din) r_state <= ST_SHIFT;
          end
          // Timeout is taken on the falling toggle so mmc_clk parks low.
          if (w_fall) begin
            r_mmc_clk <= 1'b0;
            if (r_hunt_cnt == HUNT_LIMIT) begin
              r_shreg   <= 8'hFF;
              r_to_flag <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          r_div <= w_tick ? '0 : r_div + DIV_W'(1);
          if (w_rise) begin
            r_mmc_clk <= 1'b1;
            r_bitcnt  <= r_bitcnt + 4'd1;
            if (r_dir) r_shreg <= {r_shreg[6:0], w_din};
          end
          if (w_fall) begin
            r_mmc_clk <= 1'b0;
            if (r_bitcnt == 4'd8) begin
              r_busy    <= 1'b0;
              r_dat_oe  <= DAT_IDLE_OE;
              r_dat_out <= DAT_IDLE_LEVEL;
              r_state   <= ST_DONE;
            end else if (!r_dir) begin
              r_shreg   <= {r_shreg[6:0], 1'b0};
              r_dat_out <= r_shreg[6];
            end
          end
        end
        ST_DONE: begin
          r_div <= '0;
          if (r_dir) begin
            r_rx_data   <= r_shreg;
            r_recv_flag <= 1'b1;
          end else begin
            r_sent_flag <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  kfmmc_crc16_serial u_crc (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_crc_clear),
    .i_enable (w_crc_en),
    .i_bit    (w_bit),
    .o_crc    (w_crc)
  );

  assign mmc_clk     = r_mmc_clk;
  assign mmc_dat_out = r_dat_out;
  assign mmc_dat_oe  = r_dat_oe;

  assign bus.received_data           = r_rx_data;
  assign bus.in_connecting           = r_busy;
  assign bus.sent_data_interrupt     = r_sent_flag & ~bus.mask_data_interrupt;
  assign bus.received_data_interrupt = r_recv_flag & ~bus.mask_data_interrupt;
  assign bus.start_bit_timeout       = r_to_flag;
  assign bus.data_crc                = w_crc;

endmodule

// File: tb/tb_kfmmc_data_line_shifter.sv
// Directed bench for the MMC/SD data-line shifter, acting as both the
// byte sequencer and the card on the data line.
module tb_kfmmc_data_line_shifter;

  localparam int CLK_DIV       = 4;
  localparam int START_TIMEOUT = 1024;
  localparam int BYTE_CYC      = 16 * CLK_DIV;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic mmc_clk, mmc_dat_out, mmc_dat_oe;
  logic mmc_dat_in = 1'b1;

  kfmmc_data_line_shifter_if bus ();

  kfmmc_data_line_shifter #(.CLK_DIV(CLK_DIV), .START_TIMEOUT(START_TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .mmc_clk     (mmc_clk),
    .mmc_dat_out (mmc_dat_out),
    .mmc_dat_oe  (mmc_dat_oe),
    .mmc_dat_in  (mmc_dat_in)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  logic card_bits [0:63];
  int   card_len = 0;
  logic tx_bits [0:15];
  int   pulses, busy_cycles;
  logic oe_seen, done_seen;
  logic [7:0] tx_byte;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic set_card(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) card_bits[i] = v[n-1-i];
    card_len = n;
  endtask

  task automatic idle_inputs();
    bus.start_communication  = 1'b0;
    bus.data_io              = 1'b0;
    bus.check_data_start_bit = 1'b0;
    bus.read_continuous_data = 1'b0;
    bus.clear_data_crc       = 1'b0;
    bus.clear_data_interrupt = 1'b0;
    bus.mask_data_interrupt  = 1'b0;
    bus.set_send_data        = 1'b0;
    bus.send_data            = 8'h00;
  endtask

  // Returns at the negedge of cycle N+1 (start sampled at edge N).
  task automatic do_start(input logic dio, input logic chk, input logic cont, input logic ccrc,
                          input logic cint, input logic ssend, input logic [7:0] d);
    @(negedge clock);
    bus.data_io              = dio;
    bus.check_data_start_bit = chk;
    bus.read_continuous_data = cont;
    bus.clear_data_crc       = ccrc;
    bus.clear_data_interrupt = cint;
    bus.set_send_data        = ssend;
    bus.send_data            = d;
    bus.start_communication  = 1'b1;
    mmc_dat_in = (card_len > 0) ? card_bits[0] : 1'b1;
    @(negedge clock);
    bus.start_communication  = 1'b0;
    bus.clear_data_crc       = 1'b0;
    bus.clear_data_interrupt = 1'b0;
    bus.set_send_data        = 1'b0;
  endtask

  // Watches the transfer at each negedge: counts busy cycles and mmc_clk
  // pulses, captures driven bits, and plays the card (new bit per fall).
  task automatic run_xfer(input int max_cycles, input int abort_pulses, input int glitch_at);
    logic prev;
    int   idx;
    pulses = 0; busy_cycles = 0; oe_seen = 1'b0; done_seen = 1'b0; idx = 0;
    prev = mmc_clk;
    for (int i = 0; i < 16; i++) tx_bits[i] = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      if (!bus.in_connecting) begin done_seen = 1'b1; break; end
      busy_cycles++;
      if (mmc_dat_oe) oe_seen = 1'b1;
      if (glitch_at >= 0 && c == glitch_at) begin
        bus.start_communication = 1'b1; bus.send_data = 8'hFF; bus.set_send_data = 1'b1;
        bus.clear_data_crc = 1'b1; bus.data_io = 1'b1;
      end else if (glitch_at >= 0 && c == glitch_at + 1) begin
        bus.start_communication = 1'b0; bus.set_send_data = 1'b0;
        bus.clear_data_crc = 1'b0; bus.data_io = 1'b0;
      end
      @(negedge clock);
      if (mmc_clk && !prev) begin
        if (pulses < 16) tx_bits[pulses] = mmc_dat_out;
        pulses++;
      end
      if (!mmc_clk && prev) begin
        idx++;
        mmc_dat_in = (idx < card_len) ? card_bits[idx] : 1'b1;
      end
      prev = mmc_clk;
      if (abort_pulses > 0 && pulses == abort_pulses) begin done_seen = 1'b1; break; end
    end
    for (int i = 0; i < 8; i++) tx_byte[7-i] = tx_bits[i];
  endtask

  task automatic test_reset();
    idle_inputs();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (bus.received_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", bus.received_data); end
    checks++; if (bus.data_crc !== 16'h0000) begin errors++; $display("FAIL reset_crc got=%h exp=0000", bus.data_crc); end
    checks++; if (mmc_clk !== 1'b0 || mmc_dat_out !== 1'b1 || mmc_dat_oe !== 1'b0) begin
      errors++; $display("FAIL reset_line got clk=%b out=%b oe=%b exp clk=0 out=1 oe=0", mmc_clk, mmc_dat_out, mmc_dat_oe); end
    checks++; if ({bus.in_connecting, bus.sent_data_interrupt, bus.received_data_interrupt, bus.start_bit_timeout} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {bus.in_connecting, bus.sent_data_interrupt, bus.received_data_interrupt, bus.start_bit_timeout}); end
  endtask

  task automatic test_send();
    set_card(32'h0, 0);
    do_start(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5);
    checks++; if (bus.in_connecting !== 1'b1 || mmc_dat_out !== 1'b1 || mmc_dat_oe !== 1'b1) begin
      errors++; $display("FAIL send_n1 got busy=%b out=%b oe=%b exp 1 1 1", bus.in_connecting, mmc_dat_out, mmc_dat_oe); end
    run_xfer(200, 0, -1);
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL send_done got=%b exp=1", done_seen); end
    checks++; if (busy_cycles != BYTE_CYC) begin errors++; $display("FAIL send_cycles got=%0d exp=%0d", busy_cycles, BYTE_CYC); end
    checks++; if (tx_byte !== 8'hA5 || pulses != 8) begin errors++; $display("FAIL send_bits got=%h/%0d exp=a5/8", tx_byte, pulses); end
    checks++; if (mmc_dat_oe !== 1'b0 || mmc_dat_out !== 1'b1) begin errors++; $display("FAIL send_release got oe=%b out=%b exp 0 1", mmc_dat_oe, mmc_dat_out); end
    @(negedge clock);
    checks++; if (bus.sent_data_interrupt !== 1'b1 || bus.received_data_interrupt !== 1'b0) begin
      errors++; $display("FAIL send_irq got s=%b r=%b exp 1 0", bus.sent_data_interrupt, bus.received_data_interrupt); end
    checks++; if (bus.data_crc !== crc_byte(16'h0, 8'hA5)) begin errors++; $display("FAIL send_crc got=%h exp=%h", bus.data_crc, crc_byte(16'h0, 8'hA5)); end
  endtask

  task automatic test_rx_continuous();
    set_card(32'h3C, 8);
    do_start(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    run_xfer(200, 0, -1);
    checks++; if (done_seen !== 1'b1 || pulses != 8 || busy_cycles != BYTE_CYC) begin
      errors++; $display("FAIL rxc_timing got done=%b pulses=%0d cyc=%0d exp 1 8 %0d", done_seen, pulses, busy_cycles, BYTE_CYC); end
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL rxc_oe got=%b exp=0", oe_seen); end
    @(negedge clock);
    checks++; if (bus.received_data !== 8'h3C) begin errors++; $display("FAIL rxc_data got=%h exp=3c", bus.received_data); end
    checks++; if (bus.received_data_interrupt !== 1'b1 || bus.sent_data_interrupt !== 1'b0) begin
      errors++; $display("FAIL rxc_irq got r=%b s=%b exp 1 0", bus.received_data_interrupt, bus.sent_data_interrupt); end
    checks++; if (bus.data_crc !== crc_byte(16'h0, 8'h3C)) begin errors++; $display("FAIL rxc_crc got=%h exp=%h", bus.data_crc, crc_byte(16'h0, 8'h3C)); end
  endtask

  task automatic test_rx_default_mode();
    set_card(32'h96, 8);
    do_start(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    run_xfer(200, 0, -1);
    @(negedge clock);
    checks++; if (bus.received_data !== 8'h96 || pulses != 8) begin
      errors++; $display("FAIL rxd_data got=%h/%0d exp=96/8", bus.received_data, pulses); end
  endtask

  task automatic test_rx_hunt();
    set_card(32'h3EFE, 14);
    do_start(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    run_xfer(400, 0, -1);
    checks++; if (done_seen !== 1'b1 || pulses != 14) begin errors++; $display("FAIL hunt_pulses got=%0d exp=14", pulses); end
    @(negedge clock);
    checks++; if (bus.received_data !== 8'hFE) begin errors++; $display("FAIL hunt_data got=%h exp=fe", bus.received_data); end
    checks++; if (bus.data_crc !== crc_byte(16'h0, 8'hFE) || bus.start_bit_timeout !== 1'b0) begin
      errors++; $display("FAIL hunt_crc got=%h to=%b exp=%h 0", bus.data_crc, bus.start_bit_timeout, crc_byte(16'h0, 8'hFE)); end
  endtask

  task automatic test_timeout();
    set_card(32'h0, 0);
    do_start(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    run_xfer(START_TIMEOUT * 2 * CLK_DIV + 100, 0, -1);
    checks++; if (done_seen !== 1'b1 || pulses != START_TIMEOUT) begin
      errors++; $display("FAIL to_pulses got done=%b pulses=%0d exp 1 %0d", done_seen, pulses, START_TIMEOUT); end
    @(negedge clock);
    checks++; if (bus.received_data !== 8'hFF) begin errors++; $display("FAIL to_data got=%h exp=ff", bus.received_data); end
    checks++; if (bus.start_bit_timeout !== 1'b1 || bus.received_data_interrupt !== 1'b1) begin
      errors++; $display("FAIL to_flags got to=%b r=%b exp 1 1", bus.start_bit_timeout, bus.received_data_interrupt); end
  endtask

  task automatic test_mask_clear();
    set_card(32'h0, 0);
    bus.mask_data_interrupt = 1'b1;
    do_start(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C);
    run_xfer(200, 0, -1);
    @(negedge clock);
    checks++; if (bus.sent_data_interrupt !== 1'b0 || bus.start_bit_timeout !== 1'b0) begin
      errors++; $display("FAIL mask_hold got s=%b to=%b exp 0 0", bus.sent_data_interrupt, bus.start_bit_timeout); end
    bus.mask_data_interrupt = 1'b0;
    #1;
    checks++; if (bus.sent_data_interrupt !== 1'b1) begin errors++; $display("FAIL mask_release got=%b exp=1", bus.sent_data_interrupt); end
    do_start(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    checks++; if (bus.sent_data_interrupt !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", bus.sent_data_interrupt); end
    run_xfer(200, 0, -1);
    @(negedge clock);
  endtask

  task automatic test_start_while_busy();
    set_card(32'h0, 0);
    do_start(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A);
    run_xfer(200, 0, 20);
    idle_inputs();
    checks++; if (tx_byte !== 8'h5A || busy_cycles != BYTE_CYC) begin
      errors++; $display("FAIL busy_start got=%h/%0d exp=5a/%0d", tx_byte, busy_cycles, BYTE_CYC); end
    @(negedge clock);
    checks++; if (bus.data_crc !== crc_byte(16'h0, 8'h5A) || bus.sent_data_interrupt !== 1'b1) begin
      errors++; $display("FAIL busy_crc got=%h s=%b exp=%h 1", bus.data_crc, bus.sent_data_interrupt, crc_byte(16'h0, 8'h5A)); end
  endtask

  task automatic test_back_to_back();
    set_card(32'h0, 0);
    do_start(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0F);
    run_xfer(200, 0, -1);
    do_start(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0);
    checks++; if (bus.in_connecting !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", bus.in_connecting); end
    run_xfer(200, 0, -1);
    checks++; if (tx_byte !== 8'hF0) begin errors++; $display("FAIL b2b_bits got=%h exp=f0", tx_byte); end
    @(negedge clock);
    checks++; if (bus.data_crc !== crc_byte(crc_byte(16'h0, 8'h0F), 8'hF0)) begin
      errors++; $display("FAIL b2b_crc got=%h exp=%h", bus.data_crc, crc_byte(crc_byte(16'h0, 8'h0F), 8'hF0)); end
  endtask

  task automatic test_reset_mid_shift();
    logic bad;
    set_card(32'h0, 0);
    do_start(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC3);
    run_xfer(200, 3, -1);
    checks++; if (done_seen !== 1'b1 || mmc_clk !== 1'b1) begin errors++; $display("FAIL mid_reach got done=%b clk=%b exp 1 1", done_seen, mmc_clk); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.in_connecting !== 1'b0 || mmc_clk !== 1'b0 || mmc_dat_oe !== 1'b0 || mmc_dat_out !== 1'b1) begin
      errors++; $display("FAIL mid_abort got busy=%b clk=%b oe=%b out=%b exp 0 0 0 1", bus.in_connecting, mmc_clk, mmc_dat_oe, mmc_dat_out); end
    checks++; if (bus.data_crc !== 16'h0000 || bus.received_data !== 8'h00) begin
      errors++; $display("FAIL mid_regs got crc=%h rx=%h exp 0000 00", bus.data_crc, bus.received_data); end
    @(negedge clock);
    reset = 1'b0;
    bad = 1'b0;
    repeat (BYTE_CYC + 16) begin
      @(negedge clock);
      if (mmc_clk || bus.in_connecting || bus.sent_data_interrupt || bus.received_data_interrupt) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mid_quiet got=%b exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_send();
    test_rx_continuous();
    test_rx_default_mode();
    test_rx_hunt();
    test_timeout();
    test_mask_clear();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kfmmc_data_line_shifter.md
Name: kfmmc_data_line_shifter

Overview:
- Bit-level MMC/SD data-line engine, directly downstream of the byte-level data I/O sequencer.
- Consumes the sequencer's per-byte commands (start, direction, start-bit hunt, CRC clear, interrupt clear/mask, send byte).
- Generates mmc_clk and serialises/deserialises one byte per command, MSB first, with running CRC16.
- Returns the received byte, a busy flag and sent/received interrupts to the sequencer.

Parameters:
- CLK_DIV, 4, system clocks per mmc_clk half-period (>=2).
- START_TIMEOUT, 1024, maximum mmc_clk cycles spent hunting for a start bit.

Ports:
- clock  in  1  system clock; all flops on rising edge.
- reset  in  1  asynchronous, active-high.
- start_communication  in  1  begin one byte transfer when idle.
- data_io  in  1  1 = receive, 0 = send.
- check_data_start_bit  in  1  receive: hunt for a 0 start bit before the byte.
- read_continuous_data  in  1  receive: shift 8 bits immediately, no hunt.
- clear_data_crc  in  1  zero the CRC at start.
- clear_data_interrupt  in  1  clear both interrupt flags at start.
- mask_data_interrupt  in  1  forces interrupt outputs to 0.
- set_send_data  in  1  load send_data into the shift register at start.
- send_data  in  8  byte to transmit.
- received_data  out  8  last received byte.
- in_connecting  out  1  transfer in progress.
- sent_data_interrupt  out  1  send byte complete (sticky).
- received_data_interrupt  out  1  receive byte complete (sticky).
- start_bit_timeout  out  1  last hunt timed out (sticky).
- data_crc  out  16  running CRC16-CCITT of shifted data bits.
- mmc_clk  out  1  card clock.
- mmc_dat_out  out  1  data line drive value.
- mmc_dat_oe  out  1  data line output enable.
- mmc_dat_in  in  1  data line input, synchronised by 2 flops internally.

Behaviour:
- Reset values: received_data 8'h00, data_crc 16'h0000, mmc_clk 0, mmc_dat_out 1, mmc_dat_oe 0, all flags and in_connecting 0. Reset mid-transfer aborts immediately with no interrupt.
- States: IDLE, HUNT, SHIFT, DONE.
- IDLE:
  - mmc_clk held 0, mmc_dat_out 1, mmc_dat_oe 0.
  - Start sampled high at cycle N: in_connecting=1 at N+1, divider cleared, bit counter=0.
  - Same edge: clear_data_crc zeroes CRC; clear_data_interrupt clears sent, received and timeout flags; set_send_data (send only) loads the shift register.
  - Next state: HUNT if data_io & check_data_start_bit, else SHIFT. data_io=1 with neither check_data_start_bit nor read_continuous_data is treated as read_continuous_data.
- Divider: counts 0..CLK_DIV-1. At terminal count mmc_clk toggles, so the first rising mmc_clk edge occurs at N+1+CLK_DIV.
- Send:
  - mmc_dat_oe=1; bit 7 driven from N+1.
  - Each mmc_clk rising toggle: CRC updated with the current bit. Each falling toggle: shift left, next bit driven.
- Receive:
  - mmc_dat_oe=0.
  - Synchronised mmc_dat_in sampled at each mmc_clk rising toggle, shifted into LSB, CRC updated.
- HUNT:
  - Samples on rising toggles; the first 0 is the start bit (not stored, not in CRC), then go to SHIFT.
  - START_TIMEOUT rising edges without a 0: received_data=8'hFF, start_bit_timeout=1, go to DONE.
- SHIFT: after the 8th rising toggle, wait for the falling toggle (mmc_clk returns 0), then go to DONE. A full byte takes 16*CLK_DIV cycles from N+1.
- DONE (1 cycle):
  - Receive: received_data <= shift register.
  - Set sent_data_interrupt or received_data_interrupt per direction; in_connecting=0 from this cycle; mmc_dat_oe=0, mmc_dat_out=1; go to IDLE.
- Interrupt outputs = flag & ~mask_data_interrupt. Flags persist until a start with clear_data_interrupt.
- start_communication while not IDLE is ignored.
- Back-to-back start in the cycle after DONE is accepted.
- CRC16: polynomial 0x1021, MSB-first serial form: fb = crc[15]^bit; crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).

Decomposition:
- Shared package kfmmc_pkg holds: the state enum, CRC16_POLY=16'h1021, the idle-level constants for the data line.
- One sub-module, kfmmc_crc16_serial: bit-serial CRC with clear, enable and data-bit inputs. It is reused by the command-line path.

Test Plan:
- Send: send_data=8'hA5, set_send_data, clear_data_crc, start.
  -> mmc_dat_out 1,0,1,0,0,1,0,1 across 8 mmc_clk rises; sent_data_interrupt after 16*CLK_DIV cycles; data_crc matches the model CRC of 8'hA5.
- Receive, continuous: drive 8'h3C on mmc_dat_in.
  -> received_data=8'h3C, received_data_interrupt=1, mmc_dat_oe=0 throughout.
- Receive with hunt: 5 ones, a 0, then 8'hFE.
  -> received_data=8'hFE; exactly 14 mmc_clk pulses.
- Hunt timeout: mmc_dat_in held 1.
  -> after START_TIMEOUT pulses, received_data=8'hFF, start_bit_timeout=1, received_data_interrupt=1.
- Mask and clear: complete a send with mask_data_interrupt=1.
  -> output stays 0; deassert mask -> 1; next start with clear_data_interrupt -> 0 at N+1.
- Reset mid-SHIFT after 3 bits.
  -> all outputs at reset values immediately; no interrupt.
- Start pulse while in_connecting is high.
  -> transfer unaffected.
